// File: rtl/cnn_inst_pkg.sv
// Purpose: shared constants for the CNN instruction sequencer (command words, FSM state codes).
// Latency: n/a (package only).
// Backpressure: n/a.
package cnn_inst_pkg;

    localparam int INST_W_DEF = 128;

    // Fixed command words understood by cnn_inst_executor
    localparam int unsigned CMD_RESET = 1;
    localparam int unsigned CMD_START = 2;

    // Sequencer FSM state codes
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RST    = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic [2:0] S_START  = 3'd5;
    localparam logic [2:0] S_W_BUSY = 3'd6;
    localparam logic [2:0] S_W_DONE = 3'd7;

endpackage

// File: rtl/cnn_inst_ram.sv
// Purpose: program store, simple dual-port RAM (1 write, 1 read), DEPTH x W, block-RAM style.
// Latency: 1 cycle registered read; write visible to a read issued on the following cycle.
// Backpressure: none; write strobe is gated by the caller.
// Ports: clk; we/waddr/wdata write port; raddr read address; rdata registered read data.
module cnn_inst_ram #(
    parameter int W     = 128,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // No reset on purpose: keeps the array mappable onto block RAM
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/cnn_inst_sequencer.sv
// Purpose: replays a stored program to cnn_inst_executor: RESET, run_len words, START, then waits for completion.
// Latency: one en pulse per FETCH+ISSUE+GAP_CYC (2+GAP_CYC cycles); done 1 cycle after executor ready returns.
// Backpressure: executor ready handshake only at end of pass; run/ld_we dropped while busy.
// Optional macro CNN_SEQ_TIMEOUT_EN: adds a 32-bit watchdog on the completion wait (TO_CYC cycles),
// setting sticky err_timeout and returning to idle; without it err_timeout is tied low.
// Ports: clk, rst_n; ld_we/ld_addr/ld_data program load; run/run_len/run_loop/abort control;
// cnn_inst/cnn_inst_en/cnn_inst_ready executor side; busy/done/pass_cnt/err_timeout status.
module cnn_inst_sequencer
    import cnn_inst_pkg::*;
#(
    parameter int INST_W  = INST_W_DEF,
    parameter int DEPTH   = 1024,
    parameter int GAP_CYC = 2,
    parameter int TO_CYC  = 2**24,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_we,
    input  logic [AW-1:0]     ld_addr,
    input  logic [INST_W-1:0] ld_data,
    input  logic              run,
    input  logic [AW:0]       run_len,
    input  logic              run_loop,
    input  logic              abort,
    output logic [INST_W-1:0] cnn_inst,
    output logic              cnn_inst_en,
    input  logic              cnn_inst_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pass_cnt,
    output logic              err_timeout
);

    logic [2:0]        state;
    logic [AW:0]       idx;
    logic [AW:0]       len_r;
    logic [7:0]        gap_cnt;
    logic [INST_W-1:0] inst_r;
    logic [INST_W-1:0] rd_data;
    logic              wd_expire;

    cnn_inst_ram #(
        .W     (INST_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ld_we && (state == S_IDLE)),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (idx[AW-1:0]),
        .rdata (rd_data)
    );

    // RAM data goes straight to the bus during ISSUE; inst_r then captures it so GAP holds it stable.
    assign cnn_inst    = (state == S_ISSUE) ? rd_data : inst_r;
    assign cnn_inst_en = ((state == S_RST) || (state == S_ISSUE) || (state == S_START)) && !abort;
    assign busy        = (state != S_IDLE);

`ifdef CNN_SEQ_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        err_r;

    assign wd_expire   = ((state == S_W_BUSY) || (state == S_W_DONE)) && (wd_cnt == 32'(TO_CYC - 1));
    assign err_timeout = err_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err_r  <= 1'b0;
        end else begin
            if ((state == S_W_BUSY) || (state == S_W_DONE)) begin
                wd_cnt <= wd_cnt + 32'd1;
            end else begin
                wd_cnt <= '0;
            end
            if (!abort && (state == S_IDLE) && run) begin
                err_r <= 1'b0;
            end else if (!abort && wd_expire) begin
                err_r <= 1'b1;
            end
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            len_r    <= '0;
            gap_cnt  <= '0;
            inst_r   <= '0;
            done     <= 1'b0;
            pass_cnt <= '0;
        end else begin
            done   <= 1'b0;
            inst_r <= cnn_inst;
            if (abort || wd_expire) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (run) begin
                            len_r    <= run_len;
                            idx      <= '0;
                            pass_cnt <= '0;
                            inst_r   <= INST_W'(CMD_RESET);
                            state    <= S_RST;
                        end
                    end
                    S_RST: begin
                        gap_cnt <= 8'(GAP_CYC - 1);
                        state   <= S_GAP;
                    end
                    S_FETCH: begin
                        state <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        idx     <= idx + 1'b1;
                        gap_cnt <= 8'(GAP_CYC - 1);
                        state   <= S_GAP;
                    end
                    S_GAP: begin
                        if (gap_cnt != 8'd0) begin
                            gap_cnt <= gap_cnt - 8'd1;
                        end else if (idx < len_r) begin
                            state <= S_FETCH;
                        end else begin
                            // also the zero-length path: RESET's gap leads directly to START
                            inst_r <= INST_W'(CMD_START);
                            state  <= S_START;
                        end
                    end
                    S_START: begin
                        state <= S_W_BUSY;
                    end
                    S_W_BUSY: begin
                        if (!cnn_inst_ready) begin
                            state <= S_W_DONE;
                        end
                    end
                    S_W_DONE: begin
                        if (cnn_inst_ready) begin
                            pass_cnt <= pass_cnt + 16'd1;
                            done     <= 1'b1;
                            if (run_loop) begin
                                idx    <= '0;
                                inst_r <= INST_W'(CMD_RESET);
                                state  <= S_RST;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnn_inst_sequencer.sv
// Purpose: self-checking bench for cnn_inst_sequencer with an executor model and an en-word scoreboard.
// Latency: n/a.
// Backpressure: executor model drops ready for a random or fixed number of cycles after START.
module tb_cnn_inst_sequencer;

    localparam int INST_W  = 128;
    localparam int DEPTH   = 1024;
    localparam int AW      = $clog2(DEPTH);
    localparam int GAP_CYC = 2;
    localparam int TO_CYC  = 1000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ld_we;
    logic [AW-1:0]     ld_addr;
    logic [INST_W-1:0] ld_data;
    logic              run;
    logic [AW:0]       run_len;
    logic              run_loop;
    logic              abort;
    logic [INST_W-1:0] cnn_inst;
    logic              cnn_inst_en;
    logic              cnn_inst_ready;
    logic              busy;
    logic              done;
    logic [15:0]       pass_cnt;
    logic              err_timeout;

    always #5 clk = ~clk;

    cnn_inst_sequencer #(
        .INST_W  (INST_W),
        .DEPTH   (DEPTH),
        .GAP_CYC (GAP_CYC),
        .TO_CYC  (TO_CYC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ld_we          (ld_we),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .run            (run),
        .run_len        (run_len),
        .run_loop       (run_loop),
        .abort          (abort),
        .cnn_inst       (cnn_inst),
        .cnn_inst_en    (cnn_inst_en),
        .cnn_inst_ready (cnn_inst_ready),
        .busy           (busy),
        .done           (done),
        .pass_cnt       (pass_cnt),
        .err_timeout    (err_timeout)
    );

    // Reference model state
    logic [INST_W-1:0] ram_m [DEPTH];
    logic [INST_W-1:0] exp_q [$];
    bit                exp_start_q [$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_en_cyc = -100;
    int rise_cyc = -100;
    int exec_hold = 0;
    int hold_fixed = 0;
    bit exec_stuck = 1'b0;
    int done_pending = 0;
    int model_pass = 0;

    task automatic chk(input string nm, input logic [INST_W-1:0] act, input logic [INST_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor + executor model: pops one expected word per en pulse
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && cnn_inst_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_en: got word %0h with nothing expected", cnn_inst);
                end else begin
                    logic [INST_W-1:0] e;
                    bit                is_start;
                    e        = exp_q.pop_front();
                    is_start = exp_start_q.pop_front();
                    chk("en_word", cnn_inst, e);
                    chk("en_spacing_ok", 128'(cyc - last_en_cyc >= GAP_CYC + 1), 128'(1));
                    last_en_cyc = cyc;
                    if (is_start) begin
                        done_pending++;
                        if (!exec_stuck) begin
                            exec_hold = (hold_fixed != 0) ? hold_fixed : int'($urandom_range(2, 20));
                        end
                    end
                end
            end
            if (exec_hold > 0) begin
                cnn_inst_ready = 1'b0;
                exec_hold--;
            end else if (!cnn_inst_ready) begin
                cnn_inst_ready = 1'b1;
                rise_cyc = cyc;
            end
            if (rst_n && done) begin
                if (exec_stuck || done_pending == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 required 0 (pending %0d)", done_pending);
                end else begin
                    done_pending--;
                    model_pass++;
                    chk("done_timing", 128'(cyc), 128'(rise_cyc + 1));
                    chk("pass_cnt_at_done", 128'(pass_cnt), 128'(model_pass));
                end
            end
        end
    end

    task automatic push_pass(input int len);
        exp_q.push_back(128'(1));
        exp_start_q.push_back(1'b0);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(ram_m[i]);
            exp_start_q.push_back(1'b0);
        end
        exp_q.push_back(128'(2));
        exp_start_q.push_back(1'b1);
    endtask

    task automatic load_words(input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            ld_we   = 1'b1;
            ld_addr = AW'(i);
            ld_data = ram_m[i];
        end
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic pulse_run(input int len);
        @(negedge clk);
        run_len    = (AW + 1)'(len);
        run        = 1'b1;
        model_pass = 0;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_idle"}, 128'(busy), 128'(0));
        chk({nm, "_queue_drained"}, 128'(exp_q.size()), 128'(0));
        chk({nm, "_done_seen"}, 128'(done_pending), 128'(0));
    endtask

    task automatic wait_queue_empty(input string nm, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk({nm, "_reached"}, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        int len;
        int n;
        rst_n = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0; run = 1'b0;
        run_len = '0; run_loop = 1'b0; abort = 1'b0; cnn_inst_ready = 1'b1;
        #1;
        chk("rst_inst", cnn_inst, 128'(0));
        chk("rst_en", 128'(cnn_inst_en), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_pass_cnt", 128'(pass_cnt), 128'(0));
        chk("rst_err_timeout", 128'(err_timeout), 128'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Long program, executor busy for 50 cycles
        for (int k = 0; k < 598; k++) ram_m[k] = 128'(k + 'h100);
        load_words(598);
        hold_fixed = 50;
        push_pass(598);
        pulse_run(598);
        wait_idle("long", 5000);
        chk("long_pass_cnt", 128'(pass_cnt), 128'(1));
        hold_fixed = 0;

        // Zero-length run
        push_pass(0);
        pulse_run(0);
        wait_idle("zero", 300);
        chk("zero_pass_cnt", 128'(pass_cnt), 128'(1));

        // Randomised programs
        for (int it = 0; it < 4; it++) begin
            len = int'($urandom_range(1, 40));
            for (int k = 0; k < len; k++) ram_m[k] = {$urandom, $urandom, $urandom, $urandom};
            load_words(len);
            push_pass(len);
            pulse_run(len);
            wait_idle("rand", 1000);
            chk("rand_pass_cnt", 128'(pass_cnt), 128'(1));
        end

        // Loop mode: three full passes, abort in the gap after word 2 of pass four
        len = 6;
        for (int p = 0; p < 3; p++) push_pass(len);
        exp_q.push_back(128'(1));   exp_start_q.push_back(1'b0);
        exp_q.push_back(ram_m[0]);  exp_start_q.push_back(1'b0);
        exp_q.push_back(ram_m[1]);  exp_start_q.push_back(1'b0);
        run_loop = 1'b1;
        pulse_run(len);
        wait_queue_empty("loop_pass4", 3000);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort    = 1'b0;
        run_loop = 1'b0;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_pass_cnt", 128'(pass_cnt), 128'(3));
        repeat (30) @(negedge clk);
        chk("abort_stays_idle", 128'(busy), 128'(0));
        chk("abort_pass_cnt_held", 128'(pass_cnt), 128'(3));

        // Run and load while busy must be ignored
        len = 10;
        push_pass(len);
        pulse_run(len);
        repeat (8) @(negedge clk);
        run = 1'b1; run_len = (AW + 1)'(3);
        ld_we = 1'b1; ld_addr = '0; ld_data = {4{32'hDEADBEEF}};
        @(negedge clk);
        run = 1'b0; ld_we = 1'b0;
        wait_idle("busy_ign", 1000);
        chk("busy_ign_pass_cnt", 128'(pass_cnt), 128'(1));
        push_pass(len);
        pulse_run(len);
        wait_idle("readback", 1000);

        // Executor never drops ready
        exec_stuck = 1'b1;
        push_pass(2);
        pulse_run(2);
        wait_queue_empty("stuck_start", 200);
`ifdef CNN_SEQ_TIMEOUT_EN
        n = 0;
        while (busy && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_window_ok", 128'(n >= 995 && n <= 1005), 128'(1));
        chk("timeout_busy", 128'(busy), 128'(0));
        chk("timeout_err", 128'(err_timeout), 128'(1));
        chk("timeout_pass_cnt", 128'(pass_cnt), 128'(0));
`else
        n = 0;
        repeat (1500) @(negedge clk);
        chk("stuck_busy", 128'(busy), 128'(1));
        chk("stuck_err", 128'(err_timeout), 128'(0));
        chk("stuck_pass_cnt", 128'(pass_cnt), 128'(0));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("stuck_abort_busy", 128'(busy), 128'(0));
`endif
        done_pending = 0;
        exec_stuck   = 1'b0;

        // Reset in the middle of an ISSUE cycle
        len = 8;
        for (int k = 0; k < len; k++) ram_m[k] = {$urandom, $urandom, $urandom, $urandom};
        load_words(len);
        push_pass(len);
        pulse_run(len);
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(cnn_inst_en && cnn_inst != 128'(1)) && n < 100);
        chk("mid_issue_found", 128'(cnn_inst_en), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_inst", cnn_inst, 128'(0));
        chk("mid_rst_en", 128'(cnn_inst_en), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_pass_cnt", 128'(pass_cnt), 128'(0));
        exp_q.delete();
        exp_start_q.delete();
        done_pending = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < len; k++) ram_m[k] = 128'(k + 'h5000);
        load_words(len);
        push_pass(len);
        pulse_run(len);
        wait_idle("after_rst", 1000);
        chk("after_rst_pass_cnt", 128'(pass_cnt), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
